// File: rtl/timebase_pkg.sv
// timebase_pkg: shared types and defaults for the board timebase divider
package timebase_pkg;
   localparam int TB_CNT_W = 31;
   localparam int TB_DEF_PERIOD = 100000000;
   localparam int TB_DEF_HIGH = 50000000;
   typedef enum logic [1:0] {IDLE, RUN, DRAIN} tb_state_t;
   typedef struct packed {
      logic [TB_CNT_W-1:0] period;
      logic [TB_CNT_W-1:0] high;
   } tb_cfg_t;
endpackage

// File: rtl/tick_sched_ctrl_if.sv
// tick_sched_ctrl_if: configuration valid/ready channel with error feedback
interface tick_sched_ctrl_if import timebase_pkg::*; #(parameter int CNT_W = TB_CNT_W) ();
   logic             cfg_valid;
   logic             cfg_ready;
   logic [CNT_W-1:0] cfg_period;
   logic [CNT_W-1:0] cfg_high;
   logic             cfg_err;
   modport master (output cfg_valid, cfg_period, cfg_high, input cfg_ready, cfg_err);
   modport slave (input cfg_valid, cfg_period, cfg_high, output cfg_ready, cfg_err);
endinterface

// File: rtl/tb_div_counter.sv
// tb_div_counter: divide-by-P counter with registered clkout/tick decode
module tb_div_counter import timebase_pkg::*; #(parameter int CNT_W = TB_CNT_W) (
   input  logic             clk,
   input  logic             en,
   input  logic             clr,
   input  logic [CNT_W-1:0] period,
   input  logic [CNT_W-1:0] nperiod,
   input  logic [CNT_W-1:0] nhigh,
   output logic [CNT_W-1:0] counter,
   output logic             clkout,
   output logic             tick,
   output logic             wrap
);
   logic [CNT_W-1:0] cnt_n;
   // wrap on the last count of the current period; next count decoded with next period's P/H
   always_comb begin
      wrap = en && counter == period - CNT_W'(1);
      cnt_n = !en || wrap ? '0 : counter + CNT_W'(1);
   end
   // counter, clkout and tick register together so they never skew
   always_ff @(posedge clk) begin
      if (clr) begin
         counter <= '0;
         clkout <= 1'b0;
         tick <= 1'b0;
      end else begin
         counter <= cnt_n;
         clkout <= en && cnt_n >= nperiod - nhigh;
         tick <= en && cnt_n == nperiod - CNT_W'(1);
      end
   end
endmodule

// File: rtl/tick_sched_ctrl.sv
// tick_sched_ctrl: start/run/drain sequencing and glitch-free reconfiguration of the timebase
module tick_sched_ctrl import timebase_pkg::*; #(
   parameter int               CNT_W      = TB_CNT_W,
   parameter logic [CNT_W-1:0] DEF_PERIOD = CNT_W'(TB_DEF_PERIOD),
   parameter logic [CNT_W-1:0] DEF_HIGH   = CNT_W'(TB_DEF_HIGH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             stop,
   tick_sched_ctrl_if.slave bus,
   output logic             clkout,
   output logic             tick,
   output logic [CNT_W-1:0] counter,
   output logic             busy
);
   tb_state_t state, state_n;
   tb_cfg_t   act, act_n, shd;
   logic      pend, xfer, legal, wrap;
   // handshake decode and the configuration that governs the next count
   always_comb begin
      xfer = bus.cfg_valid && bus.cfg_ready;
      legal = bus.cfg_period >= CNT_W'(2) && bus.cfg_high != '0 &&
              bus.cfg_high <= bus.cfg_period - CNT_W'(1);
      act_n = xfer && legal && state == IDLE ? tb_cfg_t'{bus.cfg_period, bus.cfg_high} :
              wrap && pend ? shd : act;
      busy = state != IDLE;
      bus.cfg_ready = !pend;
   end
   // next state; stop beats start, stop on the last count exits straight to IDLE
   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (start && !stop) state_n = RUN;
         RUN:     if (stop) state_n = wrap ? IDLE : DRAIN;
         DRAIN:   if (start && !stop) state_n = RUN; else if (wrap) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end
   // state register
   always_ff @(posedge clk) begin
      state <= rst ? IDLE : state_n;
   end
   // active/shadow configuration; a pending shadow is promoted only at a wrap
   always_ff @(posedge clk) begin
      if (rst) begin
         act <= tb_cfg_t'{DEF_PERIOD, DEF_HIGH};
         shd <= '0;
         pend <= 1'b0;
         bus.cfg_err <= 1'b0;
      end else begin
         act <= act_n;
         bus.cfg_err <= xfer && !legal;
         if (xfer && legal && state != IDLE) begin
            shd <= tb_cfg_t'{bus.cfg_period, bus.cfg_high};
            pend <= 1'b1;
         end else if (wrap) pend <= 1'b0;
      end
   end
   tb_div_counter #(.CNT_W(CNT_W)) u_div (
      .clk(clk), .en(busy), .clr(rst), .period(act.period),
      .nperiod(act_n.period), .nhigh(act_n.high),
      .counter(counter), .clkout(clkout), .tick(tick), .wrap(wrap)
   );
endmodule

// File: tb/tb_tick_sched_ctrl.sv
// tb_tick_sched_ctrl: directed checks of sequencing, waveform and reconfiguration
module tb_tick_sched_ctrl;
   logic        clk = 1'b0;
   logic        rst, start, stop;
   logic        clkout, tick, busy;
   logic [30:0] counter;
   int          tests = 0;
   int          fails = 0;

   tick_sched_ctrl_if #(.CNT_W(31)) bus ();

   tick_sched_ctrl #(.CNT_W(31), .DEF_PERIOD(31'd10), .DEF_HIGH(31'd4)) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .bus(bus),
      .clkout(clkout), .tick(tick), .counter(counter), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step(input int n = 1);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic offer(input int p, input int h);
      bus.cfg_valid = 1'b1;
      bus.cfg_period = 31'(p);
      bus.cfg_high = 31'(h);
      step();
      bus.cfg_valid = 1'b0;
   endtask

   task automatic chk_wave(input string tag, input int c, input int p, input int h);
      chk({tag, "_cnt"}, 32'(counter), 32'(c));
      chk({tag, "_clk"}, 32'(clkout), 32'(c >= p - h));
      chk({tag, "_tick"}, 32'(tick), 32'(c == p - 1));
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_cnt"}, 32'(counter), 0);
      chk({tag, "_clk"}, 32'(clkout), 0);
      chk({tag, "_tick"}, 32'(tick), 0);
      chk({tag, "_busy"}, 32'(busy), 0);
      chk({tag, "_rdy"}, 32'(bus.cfg_ready), 1);
      chk({tag, "_err"}, 32'(bus.cfg_err), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; start = 1'b0; stop = 1'b0;
      bus.cfg_valid = 1'b0; bus.cfg_period = '0; bus.cfg_high = '0;
      step(2);
      rst = 1'b0;
      chk_reset("rst");
      step();
      chk("idle_hold", 32'(counter), 0);

      start = 1'b1; step(); start = 1'b0;
      chk("run_busy", 32'(busy), 1);
      for (int i = 0; i < 20; i++) begin
         chk_wave("run", i % 10, 10, 4);
         step();
      end

      step(3);
      chk("pre_stop", 32'(counter), 3);
      stop = 1'b1; step(); stop = 1'b0;
      chk("drain_busy", 32'(busy), 1);
      for (int c = 4; c < 10; c++) begin
         chk_wave("drain", c, 10, 4);
         step();
      end
      chk("drain_end_cnt", 32'(counter), 0);
      chk("drain_end_clk", 32'(clkout), 0);
      chk("drain_end_busy", 32'(busy), 0);
      step();
      chk("idle_after", 32'(counter), 0);

      start = 1'b1; step(); start = 1'b0;
      step(9);
      chk("last_tick", 32'(tick), 1);
      stop = 1'b1; step(); stop = 1'b0;
      chk("stop_last_busy", 32'(busy), 0);
      chk("stop_last_cnt", 32'(counter), 0);

      start = 1'b1; step(); start = 1'b0;
      step(2);
      chk("cfg_rdy_pre", 32'(bus.cfg_ready), 1);
      offer(6, 2);
      chk("cfg_rdy_drop", 32'(bus.cfg_ready), 0);
      for (int c = 3; c < 10; c++) begin
         chk_wave("old", c, 10, 4);
         step();
      end
      for (int i = 0; i < 12; i++) begin
         chk_wave("new", i % 6, 6, 2);
         chk("new_rdy", 32'(bus.cfg_ready), 1);
         step();
      end

      offer(1, 1);
      chk("err_p1", 32'(bus.cfg_err), 1);
      chk("err_p1_rdy", 32'(bus.cfg_ready), 1);
      step();
      chk("err_p1_clr", 32'(bus.cfg_err), 0);
      offer(8, 8);
      chk("err_h8", 32'(bus.cfg_err), 1);
      step();
      chk("err_h8_clr", 32'(bus.cfg_err), 0);
      for (int i = 4; i < 18; i++) begin
         chk_wave("kept", i % 6, 6, 2);
         chk("kept_rdy", 32'(bus.cfg_ready), 1);
         step();
      end

      stop = 1'b1; step(); stop = 1'b0;
      chk("d2r_cnt_a", 32'(counter), 1);
      step();
      start = 1'b1; step(); start = 1'b0;
      chk("d2r_cnt", 32'(counter), 3);
      chk("d2r_busy", 32'(busy), 1);
      step(3);
      chk("d2r_wrap_cnt", 32'(counter), 0);
      chk("d2r_wrap_busy", 32'(busy), 1);
      step(5);
      stop = 1'b1; step(); stop = 1'b0;
      chk("to_idle", 32'(busy), 0);
      start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
      chk("both_busy", 32'(busy), 0);
      step();
      chk("both_busy2", 32'(busy), 0);
      chk("both_cnt", 32'(counter), 0);

      rst = 1'b1; step(); rst = 1'b0;
      start = 1'b1; step(); start = 1'b0;
      step(2);
      offer(4, 1);
      step(4);
      chk("pre_rst_cnt", 32'(counter), 7);
      chk("pre_rst_rdy", 32'(bus.cfg_ready), 0);
      rst = 1'b1; step(); rst = 1'b0;
      chk_reset("mid_rst");
      start = 1'b1; step(); start = 1'b0;
      for (int i = 0; i < 12; i++) begin
         chk_wave("post_rst", i % 10, 10, 4);
         step();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/tick_sched_ctrl.md
Name: tick_sched_ctrl

Overview:
Controller for the board timebase divider. It sequences a shared divide-by-N counter through start, run and graceful-stop phases. It accepts period and high-time reconfiguration over a valid/ready handshake and applies each new configuration only on a period boundary, so `clkout` never glitches. It sits between the lab top level (switches, buttons, bus) and every consumer of `clkout`, `tick` and `counter`.

Parameters:
- `CNT_W`, 31: width of the counter, period and high-time fields.
- `DEF_PERIOD`, 100000000: reset period in `clk` cycles (1 Hz from 100 MHz).
- `DEF_HIGH`, 50000000: reset high time in cycles.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: level or pulse; request to run.
- `stop` in 1: level or pulse; request to stop at the end of the current period.
- `cfg_valid` in 1: configuration offer.
- `cfg_ready` out 1: controller can accept a configuration.
- `cfg_period` in CNT_W: requested period.
- `cfg_high` in CNT_W: requested high time.
- `cfg_err` out 1: one-cycle pulse; the accepted configuration was illegal and has been dropped.
- `clkout` out 1: divided clock, used as an enable/level and not as a clock.
- `tick` out 1: one-cycle pulse on the last cycle of each period.
- `counter` out CNT_W: current count.
- `busy` out 1: state is not IDLE.

Behaviour:

Clocking and reset:
- All state changes on the rising edge of `clk`.
- `rst` has priority over every other input. One edge with `rst`=1 produces:
  - state=IDLE, `counter`=0, `clkout`=0, `tick`=0, `cfg_err`=0, `busy`=0, `cfg_ready`=1;
  - active period=`DEF_PERIOD`, active high=`DEF_HIGH`;
  - the pending shadow configuration is cleared.
- Reset during RUN or DRAIN discards any pending configuration.

State machine (IDLE, RUN, DRAIN):
- IDLE → RUN when `start`=1 and `stop`=0. `counter` holds 0 in IDLE. The first RUN cycle shows `counter`=0.
- RUN → DRAIN when `stop`=1. If `stop` arrives in the last cycle of a period (`counter`=P-1), go directly to IDLE.
- DRAIN → IDLE in the cycle after `counter`=P-1. `counter` returns to 0 and `clkout` to 0.
- DRAIN → RUN when `start`=1 and `stop`=0. This cancels the stop; `counter` continues without a restart.
- `start` and `stop` both asserted: `stop` wins.
- `start` in RUN is ignored. `stop` in IDLE or DRAIN is ignored.

Counting (RUN and DRAIN only):
- `counter` advances 0,1,…,P-1,0,…, where P is the active period. The wrap is the edge that moves P-1 to 0.
- `clkout`=1 exactly while `counter` ≥ P-H, where H is the active high time. The low phase comes first; `clkout` is 0 in IDLE.
- `tick`=1 exactly in the cycle where `counter`=P-1. `tick` and `clkout` are registered alongside `counter`, with no skew between them.
- Comparisons are unsigned CNT_W arithmetic, with no overflow: the legal P bounds P-1 and P-H.

Configuration handshake:
- A transfer occurs on a cycle with `cfg_valid`=1 and `cfg_ready`=1.
- Legal configuration: `cfg_period` ≥ 2 and 1 ≤ `cfg_high` ≤ `cfg_period`-1.
- Illegal configuration: accepted but dropped, `cfg_err` pulses 1 cycle later, and the active values are unchanged.
- Legal configuration in IDLE: it becomes active on the next edge.
- Legal configuration in RUN or DRAIN: it is stored in a shadow register and `cfg_ready` falls to 0 on the next cycle. At the next wrap, the shadow becomes active, the new P and H govern from `counter`=0, and `cfg_ready` returns to 1.
- If a DRAIN→IDLE transition happens with a configuration pending, the configuration is applied on that same edge.
- A configuration accepted in the same cycle as the wrap goes to the shadow and is applied at the following wrap.

Outputs:
- `busy`=1 in RUN and DRAIN.

Decomposition:
- Package `timebase_pkg`:
  - state enum `tb_state_t` {IDLE, RUN, DRAIN};
  - constants `TB_CNT_W`=31, `TB_DEF_PERIOD`, `TB_DEF_HIGH`;
  - struct `tb_cfg_t` {period, high}.
- Sub-module `tb_div_counter`: the counter, wrap detection and the `clkout`/`tick` compare. It takes enable, clear, P and H, and outputs `counter`, `clkout`, `tick` and a wrap pulse.
- The controller FSM, shadow register and handshake stay in `tick_sched_ctrl`.

Test Plan (`DEF_PERIOD`=10, `DEF_HIGH`=4 unless noted):
- Reset then `start` for 1 cycle → `counter` runs 0..9 repeatedly; `clkout`=1 for counts 6..9; `tick` at count 9 only; `busy`=1.
- `stop` pulse at count 3 → DRAIN, `counter` continues to 9, then `counter`=0, `clkout`=0, `busy`=0. A second run where `stop` pulses at count 9 → IDLE on the next edge.
- In RUN, offer `cfg_period`=6, `cfg_high`=2 at count 2 → `cfg_ready` drops 1 cycle later. The old period finishes through count 9, then `counter` runs 0..5 with `clkout` high at counts 4..5, and `cfg_ready` returns to 1.
- Offer `cfg_period`=1, and separately `cfg_period`=8 with `cfg_high`=8 → each is accepted, `cfg_err` pulses once, and the period and waveform are unchanged.
- `start` and `stop` together in IDLE → stays IDLE. In DRAIN, `start` alone → RUN with no counter discontinuity.
- `rst` asserted at count 7 with a pending configuration → next cycle all outputs reset, P=10 and H=4 active, and the pending configuration is lost.
